// File: rtl/montgomery_serial_if.sv
// Operand/result bundle for the bit-serial Montgomery multiplier.
// busy_o exists only when MONTGOMERY_BUSY_EN is defined.
interface montgomery_serial_if #(
    parameter int DATA_LENGTH = 64
);
    logic                   start_i;
    logic [DATA_LENGTH-1:0] x_i;
    logic [DATA_LENGTH-1:0] y_i;
    logic [DATA_LENGTH-1:0] m_i;
    logic [DATA_LENGTH-1:0] m_bl_i;
    logic [DATA_LENGTH-1:0] result_o;
    logic                   valid_o;
`ifdef MONTGOMERY_BUSY_EN
    logic                   busy_o;
`endif

    modport master (
        output start_i, x_i, y_i, m_i, m_bl_i,
        input  result_o, valid_o
`ifdef MONTGOMERY_BUSY_EN
        , input busy_o
`endif
    );

    modport slave (
        input  start_i, x_i, y_i, m_i, m_bl_i,
        output result_o, valid_o
`ifdef MONTGOMERY_BUSY_EN
        , output busy_o
`endif
    );
endinterface

// File: rtl/montgomery_serial.sv
// Radix-2 bit-serial Montgomery multiplier: result = x*y*2^-n mod m, one bit of x per clock.
// Optional macro MONTGOMERY_BUSY_EN adds busy_o (high in CALC and CORR).
package params_pkg;
    localparam int DATA_LENGTH = 64;
endpackage

module montgomery_serial #(
    parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    montgomery_serial_if.slave        bus
);
    localparam int CW = $clog2(DATA_LENGTH + 1);
    localparam int AW = DATA_LENGTH + 2;

    typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DATA_LENGTH-1:0] x_q, y_q, m_q, result_q;
    logic [AW-1:0]          acc_q, acc_step;
    logic [CW-1:0]          cnt_q, n_q;
    logic                   valid_q;
    logic                   last_iter, load, iterate, finish;

    // Out-of-range bit lengths fall back to the full operand width.
    function automatic logic [CW-1:0] eff_len(input logic [DATA_LENGTH-1:0] bl);
        if (bl == '0 || bl > DATA_LENGTH'(DATA_LENGTH)) return CW'(DATA_LENGTH);
        return bl[CW-1:0];
    endfunction

    function automatic logic [AW-1:0] mont_step(input logic [AW-1:0] a, input logic xb,
                                                input logic [DATA_LENGTH-1:0] y,
                                                input logic [DATA_LENGTH-1:0] m);
        logic [AW-1:0] s;
        s = a + (xb ? {2'b00, y} : '0);
        if (s[0]) s = s + {2'b00, m};
        return s >> 1;
    endfunction

    // A < 2m, so a single conditional subtraction lands in [0, m).
    function automatic logic [DATA_LENGTH-1:0] final_sub(input logic [AW-1:0] a,
                                                         input logic [DATA_LENGTH-1:0] m);
        logic [AW-1:0] d;
        d = (a >= {2'b00, m}) ? a - {2'b00, m} : a;
        return d[DATA_LENGTH-1:0];
    endfunction

    assign last_iter = (cnt_q == n_q - CW'(1));
    assign acc_step  = mont_step(acc_q, x_q[0], y_q, m_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start_i) state_d = CALC;
            CALC:       if (last_iter)   state_d = CORR;
            CORR:       state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        iterate = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE, DONE: load    = bus.start_i;
            CALC:       iterate = 1'b1;
            CORR:       finish  = 1'b1;
            default:    ;
        endcase
    end

    // x is shifted right each iteration so bit 0 is always the current multiplier bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q      <= '0;
            y_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            x_q     <= bus.x_i;
            y_q     <= bus.y_i;
            m_q     <= bus.m_i;
            n_q     <= eff_len(bus.m_bl_i);
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (iterate) begin
            acc_q <= acc_step;
            x_q   <= x_q >> 1;
            cnt_q <= cnt_q + CW'(1);
        end else if (finish) begin
            result_q <= final_sub(acc_q, m_q);
            valid_q  <= 1'b1;
        end
    end

    assign bus.result_o = result_q;
    assign bus.valid_o  = valid_q;
`ifdef MONTGOMERY_BUSY_EN
    assign bus.busy_o   = (state_q == CALC) || (state_q == CORR);
`endif
endmodule

// File: tb/tb_montgomery_serial.sv
// Scoreboard bench for montgomery_serial: directed vectors queue expectations, a monitor checks results.
module tb_montgomery_serial;
    localparam int DL = 64;
    localparam logic [DL-1:0] Q = 64'd8380417;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    montgomery_serial_if #(.DATA_LENGTH(DL)) bus();
    montgomery_serial #(.DATA_LENGTH(DL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [DL-1:0] res;
        int            due;
        int            n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every rising edge of valid_o consumes one queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            busy_cnt   = 0;
        end else begin
`ifdef MONTGOMERY_BUSY_EN
            if (bus.busy_o) busy_cnt++;
`endif
            if (bus.valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got result %0d, required no result", bus.result_o);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", longint'(bus.result_o), longint'(mon_e.res));
                    check("latency", longint'(cyc), longint'(mon_e.due));
`ifdef MONTGOMERY_BUSY_EN
                    check("busy_cycles", longint'(busy_cnt), longint'(mon_e.n + 1));
`endif
                end
                busy_cnt = 0;
            end
            prev_valid = bus.valid_o;
        end
    end

    task automatic issue(input logic [DL-1:0] x, input logic [DL-1:0] y, input logic [DL-1:0] m,
                         input logic [DL-1:0] bl, input logic [DL-1:0] exp_r,
                         input int n, input int hold);
        @(negedge clk);
        bus.x_i     = x;
        bus.y_i     = y;
        bus.m_i     = m;
        bus.m_bl_i  = bl;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp_r, cyc + n + 1, n});
        for (int k = 1; k < hold; k++) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.x_i     = ~x;
        bus.y_i     = ~y;
        bus.m_i     = ~m;
        bus.m_bl_i  = 64'd3;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.x_i     = '0;
        bus.y_i     = '0;
        bus.m_i     = '0;
        bus.m_bl_i  = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", longint'(bus.valid_o), 0);
        check("reset_result", longint'(bus.result_o), 0);
`ifdef MONTGOMERY_BUSY_EN
        check("reset_busy", longint'(bus.busy_o), 0);
`endif
        rst = 1'b0;

        // Dilithium modulus: 2 * mont(3) -> 6, then (-1) * mont(-1) -> 1.
        issue(64'd2, 64'd24573, Q, 64'd23, 64'd6, 23, 1);
        drain(100);
        issue(64'd8380416, 64'd8372226, Q, 64'd23, 64'd1, 23, 1);
        drain(100);

        // Small modulus 13, n = 4.
        issue(64'd5, 64'd8, 64'd13, 64'd4, 64'd9, 4, 1);
        drain(50);
        issue(64'd0, 64'd8, 64'd13, 64'd4, 64'd0, 4, 1);
        drain(50);

        // Start held for two edges, then a stray pulse mid-CALC.
        issue(64'd2, 64'd24573, Q, 64'd23, 64'd6, 23, 2);
        repeat (5) @(negedge clk);
        bus.x_i     = 64'd5;
        bus.y_i     = 64'd8;
        bus.m_i     = 64'd13;
        bus.m_bl_i  = 64'd4;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        drain(100);
        repeat (5) @(negedge clk);
        check("hold_valid", longint'(bus.valid_o), 1);
        check("hold_result", longint'(bus.result_o), 6);

        // Asynchronous reset in the middle of CALC aborts the operation.
        issue(64'd2, 64'd24573, Q, 64'd23, 64'd6, 23, 1);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("abort_valid", longint'(bus.valid_o), 0);
        check("abort_result", longint'(bus.result_o), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_valid", longint'(bus.valid_o), 0);
        issue(64'd1, 64'd8191, Q, 64'd23, 64'd1, 23, 1);
        drain(100);

        // Bit lengths 0 and >DATA_LENGTH fall back to 64 iterations; 64 itself is kept.
        issue(64'd5, 64'd8, 64'd13, 64'd0, 64'd9, 64, 1);
        drain(200);
        issue(64'd1, 64'd1, 64'd17, 64'd4, 64'd16, 4, 1);
        drain(50);
        issue(64'd1, 64'd1, 64'd17, 64'd0, 64'd1, 64, 1);
        drain(200);
        issue(64'd1, 64'd1, 64'd17, 64'd200, 64'd1, 64, 1);
        drain(200);
        issue(64'd1, 64'd1, 64'd17, 64'd64, 64'd1, 64, 1);
        drain(200);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
